// File: rtl/des_key_schedule_seq_if.sv
// Handshake bundle between the DES key-schedule stage and its round-datapath consumer.
// Bit 1 is the MSB of pc1_key and subkey, matching FIPS 46-3 numbering.
interface des_key_schedule_seq_if;
    logic        start;
    logic        decrypt;
    logic [1:56] pc1_key;
    logic [1:48] subkey;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [3:0]  round_idx;
    logic        busy;
    logic        done;

    modport master (
        output start, decrypt, pc1_key, subkey_ready,
        input  subkey, subkey_valid, round_idx, busy, done
    );

    modport slave (
        input  start, decrypt, pc1_key, subkey_ready,
        output subkey, subkey_valid, round_idx, busy, done
    );
endinterface

// File: rtl/des_key_schedule_seq.sv
// Sequential DES key schedule: rotates C/D halves per round and streams PC-2 subkeys
// over a valid/ready handshake, K1..K16 for encrypt and K16..K1 for decrypt.
module des_key_schedule_seq #(
    parameter int unsigned NUM_ROUNDS = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    des_key_schedule_seq_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [3:0] LAST = 4'(NUM_ROUNDS - 1);

    state_t      state;
    logic [1:28] c;
    logic [1:28] d;
    logic [3:0]  r;
    logic        dir;

    logic [1:56] cd;
    logic        xfer;
    logic        last;
    logic        single;

    // Rotation amount is 1 at r = 0, 7, 14 in both directions: encrypt walks LS[r+2],
    // decrypt walks LS[16-r], and those two index sets hit the 1-shift entries at the same r.
    function automatic logic [1:28] step(input logic [1:28] h, input logic right, input logic one);
        logic [1:28] res;
        case ({right, one})
            2'b01:   res = {h[2:28], h[1]};
            2'b00:   res = {h[3:28], h[1:2]};
            2'b11:   res = {h[28], h[1:27]};
            default: res = {h[27:28], h[1:26]};
        endcase
        return res;
    endfunction

    assign cd     = {c, d};
    assign xfer   = (state == RUN) && bus.subkey_ready;
    assign last   = (r == LAST);
    assign single = (r == 4'd0) || (r == 4'd7) || (r == 4'd14);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            c     <= '0;
            d     <= '0;
            r     <= '0;
            dir   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        dir   <= bus.decrypt;
                        r     <= '0;
                        state <= RUN;
                        if (bus.decrypt) begin
                            c <= bus.pc1_key[1:28];
                            d <= bus.pc1_key[29:56];
                        end else begin
                            c <= step(bus.pc1_key[1:28], 1'b0, 1'b1);
                            d <= step(bus.pc1_key[29:56], 1'b0, 1'b1);
                        end
                    end
                end
                RUN: begin
                    if (xfer) begin
                        if (last) begin
                            state <= IDLE;
                            r     <= '0;
                        end else begin
                            r <= r + 4'd1;
                            c <= step(c, dir, single);
                            d <= step(d, dir, single);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.subkey = {
        cd[14], cd[17], cd[11], cd[24], cd[1],  cd[5],
        cd[3],  cd[28], cd[15], cd[6],  cd[21], cd[10],
        cd[23], cd[19], cd[12], cd[4],  cd[26], cd[8],
        cd[16], cd[7],  cd[27], cd[20], cd[13], cd[2],
        cd[41], cd[52], cd[31], cd[37], cd[47], cd[55],
        cd[30], cd[40], cd[51], cd[45], cd[33], cd[48],
        cd[44], cd[49], cd[39], cd[56], cd[34], cd[53],
        cd[46], cd[42], cd[50], cd[36], cd[29], cd[32]
    };

    assign bus.subkey_valid = (state == RUN);
    assign bus.busy         = (state == RUN);
    assign bus.round_idx    = r;
    assign bus.done         = xfer && last;
endmodule

// File: tb/tb_des_key_schedule_seq.sv
// Scoreboard bench for des_key_schedule_seq using the classic FIPS 46-3 worked-example key.
module tb_des_key_schedule_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    des_key_schedule_seq_if bus();

    des_key_schedule_seq #(.NUM_ROUNDS(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [47:0] key;
        logic [3:0]  idx;
    } exp_t;

    localparam logic [55:0] KEY = 56'hF0CCAAF556678F;

    logic [47:0] kenc [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   xfers = 0;
    int   dones = 0;
    int   rdy_mode = 0;
    int   burst = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Ready driver: always high, or random with occasional 5-cycle low bursts.
    initial begin
        bus.subkey_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) begin
                bus.subkey_ready = 1'b1;
            end else if (burst > 0) begin
                bus.subkey_ready = 1'b0;
                burst--;
            end else if ($urandom_range(0, 7) == 0) begin
                bus.subkey_ready = 1'b0;
                burst = 4;
            end else begin
                bus.subkey_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: compares every valid cycle against the queue head; pops on transfer.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.subkey_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_valid", 64'(bus.subkey_valid), 64'd0);
                    end else begin
                        check("busy_run", 64'(bus.busy), 64'd1);
                        check("subkey", 64'(bus.subkey), 64'(exp_q[0].key));
                        check("round_idx", 64'(bus.round_idx), 64'(exp_q[0].idx));
                        if (bus.subkey_ready) begin
                            check("done_xfer", 64'(bus.done), 64'(exp_q[0].idx == 4'd15));
                            xfers++;
                            if (bus.done) dones++;
                            void'(exp_q.pop_front());
                        end else begin
                            check("done_stall", 64'(bus.done), 64'd0);
                        end
                    end
                end else begin
                    check("busy_idle", 64'(bus.busy), 64'd0);
                    check("done_idle", 64'(bus.done), 64'd0);
                end
            end
        end
    end

    // kind 0: worked-example table, 1: all zeros, 2: all ones
    task automatic start_job(input logic [55:0] key, input logic dec, input int kind);
        exp_t e;
        bus.start   = 1'b1;
        bus.decrypt = dec;
        bus.pc1_key = key;
        xfers = 0;
        dones = 0;
        for (int i = 0; i < 16; i++) begin
            e.idx = 4'(i);
            if (kind == 1)      e.key = '0;
            else if (kind == 2) e.key = '1;
            else                e.key = dec ? kenc[15 - i] : kenc[i];
            exp_q.push_back(e);
        end
        cyc();
        bus.start   = 1'b0;
        bus.pc1_key = ~key;
        bus.decrypt = ~dec;
        check("latency_valid", 64'(bus.subkey_valid), 64'd1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < 400) begin
            cyc();
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s actual=%0d required=0 pending", name, exp_q.size());
            exp_q.delete();
        end
        check({"xfers_", name}, 64'(xfers), 64'd16);
        check({"dones_", name}, 64'(dones), 64'd1);
    endtask

    task automatic wait_idx(input logic [3:0] idx, input string name);
        int n = 0;
        while (bus.round_idx != idx && n < 100) begin
            cyc();
            n++;
        end
        check({"reach_", name}, 64'(bus.round_idx), 64'(idx));
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.decrypt = 1'b0;
        bus.pc1_key = '0;
        rst_n = 1'b0;
        repeat (3) cyc();
        check("rst_valid", 64'(bus.subkey_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_idx", 64'(bus.round_idx), 64'd0);
        check("rst_subkey", 64'(bus.subkey), 64'd0);
        rst_n = 1'b1;
        cyc();

        // T1 / T2: encrypt then decrypt, ready always high
        start_job(KEY, 1'b0, 0);
        wait_idle("t1_enc");
        cyc();
        start_job(KEY, 1'b1, 0);
        wait_idle("t2_dec");
        cyc();

        // T3: backpressure
        rdy_mode = 1;
        start_job(KEY, 1'b0, 0);
        wait_idle("t3_bp");
        rdy_mode = 0;
        repeat (2) cyc();

        // T4: reset at round 7, then replay from K1
        start_job(KEY, 1'b0, 0);
        wait_idx(4'd7, "t4_idx7");
        rst_n = 1'b0;
        #1;
        check("t4_valid", 64'(bus.subkey_valid), 64'd0);
        check("t4_busy", 64'(bus.busy), 64'd0);
        check("t4_done", 64'(bus.done), 64'd0);
        check("t4_idx", 64'(bus.round_idx), 64'd0);
        exp_q.delete();
        cyc();
        rst_n = 1'b1;
        cyc();
        start_job(KEY, 1'b0, 0);
        wait_idle("t4_replay");
        cyc();

        // T5: start pulses mid-job and on the done cycle are ignored
        start_job(KEY, 1'b1, 0);
        wait_idx(4'd4, "t5_idx4");
        bus.start   = 1'b1;
        bus.decrypt = 1'b0;
        bus.pc1_key = 56'h123456789ABCDE;
        cyc();
        bus.start = 1'b0;
        wait_idx(4'd15, "t5_idx15");
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        wait_idle("t5_ignore");
        repeat (3) begin
            check("t5_no_restart", 64'(bus.busy), 64'd0);
            cyc();
        end

        // T6: degenerate keys in both directions
        start_job(56'h0, 1'b0, 1);
        wait_idle("t6_zero_enc");
        cyc();
        start_job(56'h0, 1'b1, 1);
        wait_idle("t6_zero_dec");
        cyc();
        start_job(56'hFFFFFFFFFFFFFF, 1'b0, 2);
        wait_idle("t6_ones_enc");
        cyc();
        start_job(56'hFFFFFFFFFFFFFF, 1'b1, 2);
        wait_idle("t6_ones_dec");
        repeat (2) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
